hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Parametrised successor to the two-stage EX/MEM forwarding unit. Keeps a registered scoreboard of destination registers for FWD_STAGES downstream pipeline stages (stage 1 = EX, 2 = MEM, 3 = WB by default). Every cycle it produces per-operand forwarding selects for the instruction in decode, plus a load-use stall. Sits beside the datapath and is fed from the decode stage. Its outputs drive the operand muxes and the PC/IF-ID hold logic.

Parameters:
REG_W, 5, register address width
FWD_STAGES, 3, number of tracked downstream stages (EX..WB), minimum 2
LOAD_STAGE, 2, first stage whose load result can be forwarded; must satisfy 1 < LOAD_STAGE <= FWD_STAGES
CNT_W, 16, width of the stall-cycle statistics counter
SEL_W, $clog2(FWD_STAGES+1), width of each forwarding select

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
id_valid  in  1  decode holds a real instruction
id_rs  in  REG_W  source A register
id_rt  in  REG_W  source B register
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_dest  in  REG_W  destination register
id_wen  in  1  instruction writes id_dest
id_is_load  in  1  instruction is a load
pipe_en  in  1  pipeline advances this cycle; low during memory wait
flush  in  1  squash the decode instruction (branch/jump taken)
stall  out  1  hold PC and IF/ID; insert bubble into EX
fwd_sel_rs  out  SEL_W  0 = register file, k = forward from stage k
fwd_sel_rt  out  SEL_W  same, for rt
stall_cnt  out  CNT_W  saturating count of cycles with stall=1 and pipe_en=1

Behaviour:
- Scoreboard entry sb[k], k=1..FWD_STAGES, holds {v, dest, ld}.
- Reset (RST=1 at a CLK edge): all sb[k].v=0, dest=0, ld=0, stall_cnt=0. Outputs then read stall=0, fwd_sel_rs=fwd_sel_rt=0. RST overrides all other inputs.
- Update rules at the CLK edge:
  - pipe_en=0: scoreboard and stall_cnt hold; flush is ignored.
  - pipe_en=1: sb[k] <= sb[k-1] for k>=2. The oldest entry drops off.
  - pipe_en=1 and stall=0 and flush=0: sb[1] <= {id_valid & id_wen & (id_dest!=0), id_dest, id_is_load}.
  - pipe_en=1 and (stall=1 or flush=1): sb[1] <= bubble (v=0).
- Match for operand X (rs or rt): requires X_used, id_valid, X!=0, sb[k].v, and sb[k].dest==X.
- Resolution: take the youngest stage only, i.e. the smallest k that matches.
  - If sb[k].ld and k < LOAD_STAGE: the operand is a hazard and its select is 0.
  - Otherwise the select is k.
  - With no match the select is 0.
  - An older match never overrides a younger one, even when the younger one is a load hazard.
- stall = id_valid & ~flush & (hazard on rs | hazard on rt). Combinational from scoreboard state and decode inputs; zero added latency.
- With the defaults, a load-use dependence stalls exactly 1 cycle. In general it stalls LOAD_STAGE-1 cycles while pipe_en is held high. Cycles with pipe_en=0 extend the stall without changing the scoreboard.
- stall_cnt increments when stall=1 and pipe_en=1, and saturates at all-ones.
- Forwarding and stall outputs are combinational; only the scoreboard and stall_cnt are registered.

Test Plan:
- Reset, then idle: RST=1 for 2 cycles, then id_valid=0 -> stall=0, fwd_sel_rs=fwd_sel_rt=0, stall_cnt=0.
- Back-to-back ALU dependence: issue add dest=8; next cycle decode rs=8 -> fwd_sel_rs=1. One cycle later (no new write to 8) -> fwd_sel_rs=2, then 3, then 0.
- Load-use: issue lw dest=9; next cycle decode rt=9 with id_rt_used=1 -> stall=1 for exactly 1 cycle. The bubble enters sb[1]; the next cycle gives stall=0, fwd_sel_rt=2, and stall_cnt=1.
- Youngest wins, and register 0: add dest=5, then sub dest=5, then decode rs=5 -> fwd_sel_rs=1. With rs=0 and sb[1].dest=0 written -> fwd_sel_rs=0.
- Memory wait during stall: lw dest=4, dependent rs=4 with pipe_en=0 for 3 cycles -> stall=1 held and scoreboard frozen. stall_cnt is unchanged until pipe_en=1, then the stall clears after 1 advancing cycle.
- Flush and mid-operation reset: flush=1 while decode has lw dest=7 -> sb[1].v=0 and no later stall on 7. Separately, assert RST with sb loaded -> next cycle all selects 0 and stall=0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: a registered scoreboard of downstream destinations
// drives per-operand forwarding selects and the load-use stall.

module hfu_operand_resolve #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  logic                             id_valid,
    input  logic                             src_used,
    input  logic [REG_W-1:0]                 src,
    input  logic [FWD_STAGES:1]              sb_vld,
    input  logic [FWD_STAGES:1][REG_W-1:0]   sb_dest,
    input  logic [FWD_STAGES:1]              sb_ld,
    output logic [SEL_W-1:0]                 sel,
    output logic                             hazard
);

    // Walk oldest to youngest so the youngest match is the one left standing;
    // a young load hazard therefore masks any older forwardable copy.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        if (id_valid && src_used && (src != '0)) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (sb_vld[k] && (sb_dest[k] == src)) begin
                    sel    = SEL_W'(k);
                    hazard = sb_ld[k] && (k < LOAD_STAGE);
                end
            end
            if (hazard) sel = '0;
        end
    end

endmodule

module hazard_forward_unit #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              pipe_en,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_rs,
    output logic [SEL_W-1:0]  fwd_sel_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NUM_OPS = 2;

    logic [FWD_STAGES:1]             vld_pipe;
    logic [FWD_STAGES:1][REG_W-1:0]  sb_dest;
    logic [FWD_STAGES:1]             sb_ld;

    logic [NUM_OPS-1:0][REG_W-1:0]   op_src;
    logic [NUM_OPS-1:0]              op_used;
    logic [NUM_OPS-1:0][SEL_W-1:0]   op_sel;
    logic [NUM_OPS-1:0]              op_hazard;

    assign op_src  = {id_rt, id_rs};
    assign op_used = {id_rt_used, id_rs_used};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        hfu_operand_resolve #(
            .REG_W      (REG_W),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_res (
            .id_valid (id_valid),
            .src_used (op_used[i]),
            .src      (op_src[i]),
            .sb_vld   (vld_pipe),
            .sb_dest  (sb_dest),
            .sb_ld    (sb_ld),
            .sel      (op_sel[i]),
            .hazard   (op_hazard[i])
        );
    end

    assign fwd_sel_rs = op_sel[0];
    assign fwd_sel_rt = op_sel[1];
    assign stall      = id_valid && !flush && (|op_hazard);

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe  <= '0;
            sb_dest   <= '0;
            sb_ld     <= '0;
            stall_cnt <= '0;
        end else if (pipe_en) begin
            for (int k = 2; k <= FWD_STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                sb_dest[k]  <= sb_dest[k-1];
                sb_ld[k]    <= sb_ld[k-1];
            end
            // Stalled or flushed decode slots enter EX as bubbles.
            vld_pipe[1] <= !stall && !flush && id_valid && id_wen && (id_dest != '0);
            sb_dest[1]  <= id_dest;
            sb_ld[1]    <= id_is_load;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: cycle table of decode inputs with
// hand-computed stall/select/counter values, plus a memory-wait sequence.

module tb_hazard_forward_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_rs_used, id_rt_used, id_wen, id_is_load;
    logic        pipe_en, flush;
    logic        stall;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    hazard_forward_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_dest    (id_dest),
        .id_wen     (id_wen),
        .id_is_load (id_is_load),
        .pipe_en    (pipe_en),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel_rs (fwd_sel_rs),
        .fwd_sel_rt (fwd_sel_rt),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        string       name;
        bit          chk;
        logic        rst, v;
        logic [4:0]  rs, rt;
        logic        ru, tu;
        logic [4:0]  dest;
        logic        wen, ld, pe, fl;
        logic        e_stall;
        logic [1:0]  e_srs, e_srt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input bit chk, input logic rst, input logic v,
                       input logic [4:0] rs, input logic ru, input logic [4:0] rt, input logic tu,
                       input logic [4:0] dest, input logic wen, input logic ld,
                       input logic pe, input logic fl,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert,
                       input logic [15:0] ec);
        vec_t t;
        t.name = name; t.chk = chk; t.rst = rst; t.v = v;
        t.rs = rs; t.ru = ru; t.rt = rt; t.tu = tu;
        t.dest = dest; t.wen = wen; t.ld = ld; t.pe = pe; t.fl = fl;
        t.e_stall = es; t.e_srs = ers; t.e_srt = ert; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [4:0] rs, input logic ru,
                         input logic [4:0] rt, input logic tu, input logic [4:0] dest,
                         input logic wen, input logic ld, input logic pe, input logic fl);
        RST = rst; id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
        id_dest = dest; id_wen = wen; id_is_load = ld; pipe_en = pe; flush = fl;
    endtask

    task automatic check_out(input string name, input logic es, input logic [1:0] ers,
                             input logic [1:0] ert, input logic [15:0] ec);
        check({name, ".stall"},      {31'd0, stall},      {31'd0, es});
        check({name, ".fwd_sel_rs"}, {30'd0, fwd_sel_rs}, {30'd0, ers});
        check({name, ".fwd_sel_rt"}, {30'd0, fwd_sel_rt}, {30'd0, ert});
        check({name, ".stall_cnt"},  {16'd0, stall_cnt},  {16'd0, ec});
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        //   name          chk rst v  rs ru rt tu dst wen ld pe fl | stall srs srt cnt
        add("rst0",         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        add("rst1",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        add("idle",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        add("add8",         1, 0, 1, 1, 0, 2, 0, 8, 1, 0, 1, 0,   0, 0, 0, 0);
        add("use8_s1",      1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0);
        add("use8_s2",      1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0,   0, 2, 0, 0);
        add("use8_s3",      1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0,   0, 3, 0, 0);
        add("use8_gone",    1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        add("lw9",          1, 0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 0,   0, 0, 0, 0);
        add("use9_stall",   1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        add("use9_fwd",     1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0,   0, 0, 2, 1);
        add("add5",         1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0,   0, 0, 0, 1);
        add("sub5",         1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0,   0, 0, 0, 1);
        add("use5_young",   1, 0, 1, 5, 1, 0, 1, 0, 1, 0, 1, 0,   0, 1, 0, 1);
        add("rs0_rt5",      1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 1, 0,   0, 0, 2, 1);
        add("add6",         1, 0, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0,   0, 0, 0, 1);
        add("lw6",          1, 0, 1, 0, 0, 0, 0, 6, 1, 1, 1, 0,   0, 0, 0, 1);
        add("use6_shadow",  1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1);
        add("use6_fwd",     1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0,   0, 2, 0, 2);
        add("lw4",          1, 0, 1, 0, 0, 0, 0, 4, 1, 1, 1, 0,   0, 0, 0, 2);
        add("use4_wait1",   1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2);
        add("use4_wait2",   1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2);
        add("use4_wait3",   1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2);
        add("use4_adv",     1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 2);
        add("use4_fwd",     1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0,   0, 2, 0, 3);
        add("lw7_flush",    1, 0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 1,   0, 0, 0, 3);
        add("use7_none",    1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0,   0, 0, 0, 3);
        add("lw7",          1, 0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0,   0, 0, 0, 3);
        add("use7_flush",   1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1,   0, 0, 0, 3);
        add("use7_fwd",     1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0,   0, 0, 2, 3);
        add("add10",        1, 0, 1, 0, 0, 0, 0,10, 1, 0, 1, 0,   0, 0, 0, 3);
        add("lw11",         1, 0, 1, 0, 0, 0, 0,11, 1, 1, 1, 0,   0, 0, 0, 3);
        add("rst_loaded",   1, 1, 1,10, 1,11, 1, 0, 0, 0, 1, 0,   1, 2, 0, 3);
        add("after_rst",    1, 0, 1,10, 1,11, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0);

        @(posedge CLK); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].rs, vecs[i].ru, vecs[i].rt, vecs[i].tu,
                  vecs[i].dest, vecs[i].wen, vecs[i].ld, vecs[i].pe, vecs[i].fl);
            @(negedge CLK);
            if (vecs[i].chk)
                check_out(vecs[i].name, vecs[i].e_stall, vecs[i].e_srs, vecs[i].e_srt, vecs[i].e_cnt);
            @(posedge CLK); #1;
        end

        // Stall counter only counts advancing cycles; both operands hit one load.
        drive(0, 1, 0, 0, 0, 0, 3, 1, 1, 1, 0);
        @(negedge CLK); check_out("lw3", 0, 0, 0, 0);
        @(posedge CLK); #1;
        drive(0, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0);
        @(negedge CLK); check_out("use3_hold", 1, 0, 0, 0);
        @(posedge CLK); #1;
        pipe_en = 1'b1;
        @(negedge CLK); check_out("use3_adv", 1, 0, 0, 0);
        @(posedge CLK); #1;
        @(negedge CLK); check_out("use3_fwd", 0, 2, 2, 1);
        @(posedge CLK); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
